// File: rtl/gmii_tx_arbiter.sv
// Two-requester GMII transmit arbiter. Round-robin grant per frame, then
// preamble, SFD, payload pass-through and a fixed inter-frame gap. Underruns
// and oversize frames end in a one-cycle error symbol (tx_en=1, tx_er=1).
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | no owner; first valid requester is granted at the next edge
// PREAMBLE  | 0x55 for PREAMBLE_BYTES cycles
// SFD       | 0xD5 on the wire; first payload byte may be taken here
// DATA      | payload bytes on the wire; holds one extra cycle after last
// ABORT     | single error symbol after underrun or oversize
// IFG       | wire idle for IFG_BYTES cycles, grant still held
//
// Output registers are loaded from the next state, so the wire always shows
// the pattern of the state the block is in. Timers hold at most 255.

module gmii_tx_arbiter #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12,
    parameter int MAX_BYTES      = 1518
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic [1:0] grant,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_SFD      = 3'd2,
        S_DATA     = 3'd3,
        S_ABORT    = 3'd4,
        S_IFG      = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  tmr_q, tmr_d;
    logic [10:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;

    logic        sel_valid;
    logic [7:0]  sel_data;
    logic        sel_last;
    logic        take_ok;
    logic        accept;
    logic        pick1;

    // Route the owner's stream and decide whether a byte can be taken this cycle
    always_comb begin
        sel_valid = grant_q[1] ? req1_valid : req0_valid;
        sel_data  = grant_q[1] ? req1_data  : req0_data;
        sel_last  = grant_q[1] ? req1_last  : req0_last;
        // ready drops once last is taken, and also once MAX_BYTES are taken so
        // the oversize byte is never accepted
        take_ok   = (state_q == S_SFD) ||
                    ((state_q == S_DATA) && !done_q && (cnt_q != 11'(MAX_BYTES)));
        accept    = take_ok && sel_valid;
    end

    assign req0_ready = take_ok & grant_q[0];
    assign req1_ready = take_ok & grant_q[1];

    // Next-state, timers, payload counter, arbitration and wire pattern
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        grant_d = grant_q;
        last_d  = last_q;
        pick1   = 1'b0;
        txd_d   = 8'h00;
        tx_en_d = 1'b0;
        tx_er_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    // on a tie, serve whoever was not served last
                    pick1   = req1_valid && (!req0_valid || !last_q);
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    last_d  = pick1;
                    state_d = S_PREAMBLE;
                    tmr_d   = 8'(PREAMBLE_BYTES - 1);
                    cnt_d   = 11'd0;
                    done_d  = 1'b0;
                end
            end
            S_PREAMBLE: begin
                if (tmr_q == 8'd0) begin
                    state_d = S_SFD;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            S_SFD, S_DATA: begin
                if (take_ok) begin
                    if (sel_valid) begin
                        cnt_d   = cnt_q + 11'd1;
                        done_d  = sel_last;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_ABORT;
                    end
                end else if (done_q) begin
                    state_d = S_IFG;
                    tmr_d   = 8'(IFG_BYTES - 1);
                end else begin
                    state_d = S_ABORT;
                end
            end
            S_ABORT: begin
                state_d = S_IFG;
                tmr_d   = 8'(IFG_BYTES - 1);
            end
            S_IFG: begin
                if (tmr_q == 8'd0) begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase

        if (accept) begin
            txd_d   = sel_data;
            tx_en_d = 1'b1;
        end else begin
            case (state_d)
                S_PREAMBLE: begin
                    txd_d   = 8'h55;
                    tx_en_d = 1'b1;
                end
                S_SFD: begin
                    txd_d   = 8'hD5;
                    tx_en_d = 1'b1;
                end
                S_ABORT: begin
                    tx_en_d = 1'b1;
                    tx_er_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State and output registers; reset clears everything mid-frame
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tmr_q   <= 8'd0;
            cnt_q   <= 11'd0;
            done_q  <= 1'b0;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            txd_q   <= 8'h00;
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            txd_q   <= txd_d;
            tx_en_q <= tx_en_d;
            tx_er_q <= tx_er_d;
        end
    end

    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
    assign grant      = grant_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Bench for gmii_tx_arbiter. A per-cycle expected wire image (txd, en, er,
// grant, busy, both readies) is queued at each grant edge and compared on the
// falling edge; when the queue is empty the wire must be idle.

module tb_gmii_tx_arbiter;

    localparam int PRE  = 7;
    localparam int IFG  = 12;
    localparam int MAXB = 1518;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_last = 1'b0, req1_last = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en, gmii_tx_er;
    logic [1:0] grant;
    logic       busy;

    gmii_tx_arbiter #(
        .PREAMBLE_BYTES(PRE),
        .IFG_BYTES(IFG),
        .MAX_BYTES(MAXB)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .req0_valid(req0_valid),
        .req0_data(req0_data),
        .req0_last(req0_last),
        .req1_valid(req1_valid),
        .req1_data(req1_data),
        .req1_last(req1_last),
        .req0_ready(req0_ready),
        .req1_ready(req1_ready),
        .gmii_txd(gmii_txd),
        .gmii_tx_en(gmii_tx_en),
        .gmii_tx_er(gmii_tx_er),
        .grant(grant),
        .busy(busy)
    );

    always #4 clock = ~clock;

    typedef struct {
        logic [7:0] txd;
        logic       en;
        logic       er;
        logic [1:0] gnt;
        logic       busy;
        logic       rdy0;
        logic       rdy1;
    } wire_t;

    typedef struct {
        int req;
        int n;
        bit use_last;
        int avail;
        int exp_acc;
        bit exp_abort;
    } vec_t;

    wire_t exp_q[$];
    wire_t mon_e;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] pack_act();
        return {1'b0, gmii_txd, gmii_tx_en, gmii_tx_er, grant, busy, req0_ready, req1_ready};
    endfunction

    function automatic logic [15:0] pack_exp(wire_t e);
        return {1'b0, e.txd, e.en, e.er, e.gnt, e.busy, e.rdy0, e.rdy1};
    endfunction

    function automatic logic [7:0] pat(int req, int i);
        if (req == 0) return 8'((i + 1) * 17);
        return 8'(160 + i * 3);
    endfunction

    function automatic wire_t mk(logic [7:0] txd, logic en, logic er, logic [1:0] g,
                                 logic bsy, logic r0, logic r1);
        wire_t w;
        w.txd = txd; w.en = en; w.er = er; w.gnt = g;
        w.busy = bsy; w.rdy0 = r0; w.rdy1 = r1;
        return w;
    endfunction

    // Expected wire image of one granted frame, starting the cycle after the grant edge
    function automatic void push_frame(int req, int n_acc, bit abrt);
        logic [1:0] g;
        logic       r;
        logic       is0;
        is0 = (req == 0);
        g = is0 ? 2'b01 : 2'b10;
        for (int i = 0; i < PRE; i++) exp_q.push_back(mk(8'h55, 1'b1, 1'b0, g, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(8'hD5, 1'b1, 1'b0, g, 1'b1, is0, !is0));
        for (int i = 1; i <= n_acc; i++) begin
            r = !(((i == n_acc) && !abrt) || (i == MAXB));
            exp_q.push_back(mk(pat(req, i - 1), 1'b1, 1'b0, g, 1'b1, r && is0, r && !is0));
        end
        if (abrt) exp_q.push_back(mk(8'h00, 1'b1, 1'b1, g, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < IFG; i++) exp_q.push_back(mk(8'h00, 1'b0, 1'b0, g, 1'b1, 1'b0, 1'b0));
    endfunction

    // Wire monitor, sampled on the falling edge
    always @(negedge clock) begin
        if (mon_en && reset_n) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("frame_wire", pack_act(), pack_exp(mon_e));
            end else begin
                check("idle_wire", pack_act(), 16'h0000);
            end
        end
    end

    task automatic drive(int req, int idx, int n, bit use_last, bit on);
        logic l;
        l = on && use_last && (idx == n - 1);
        if (req == 0) begin
            req0_valid = on; req0_data = pat(0, idx); req0_last = l;
        end else begin
            req1_valid = on; req1_data = pat(1, idx); req1_last = l;
        end
    endtask

    // Call at posedge+1 with the DUT in IDLE; returns at posedge+1 of the next IDLE cycle
    task automatic send_frame(int req, int n, bit use_last, int avail, int n_acc, bit abrt);
        int idx;
        int len;
        int abort_pos;
        bit acc;
        bit on;
        idx = 0;
        len = 8 + n_acc + (abrt ? 1 : 0) + IFG;
        abort_pos = 8 + n_acc;
        drive(req, 0, n, use_last, 1'b1);
        @(posedge clock);
        push_frame(req, n_acc, abrt);
        #1;
        for (int j = 0; j < len; j++) begin
            @(negedge clock);
            acc = (req == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
            @(posedge clock);
            #1;
            if (acc) idx++;
            on = ((j + 1) < PRE) || ((idx < avail) && ((j + 1) < abort_pos));
            drive(req, idx, n, use_last, on);
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{req: 0, n: 3,    use_last: 1'b1, avail: 3,    exp_acc: 3,    exp_abort: 1'b0};
        vecs[1] = '{req: 1, n: 5,    use_last: 1'b1, avail: 5,    exp_acc: 5,    exp_abort: 1'b0};
        vecs[2] = '{req: 1, n: 6,    use_last: 1'b1, avail: 2,    exp_acc: 2,    exp_abort: 1'b1};
        vecs[3] = '{req: 0, n: 1,    use_last: 1'b1, avail: 1,    exp_acc: 1,    exp_abort: 1'b0};
        vecs[4] = '{req: 0, n: 4,    use_last: 1'b1, avail: 0,    exp_acc: 0,    exp_abort: 1'b1};
        vecs[5] = '{req: 0, n: 1519, use_last: 1'b0, avail: 1519, exp_acc: 1518, exp_abort: 1'b1};
        vecs[6] = '{req: 0, n: 1518, use_last: 1'b1, avail: 1518, exp_acc: 1518, exp_abort: 1'b0};
        vecs[7] = '{req: 1, n: 2,    use_last: 1'b1, avail: 2,    exp_acc: 2,    exp_abort: 1'b0};

        #3;
        check("reset_state", pack_act(), 16'h0000);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        mon_en = 1'b1;

        // last without valid must not start a frame
        req0_last = 1'b1;
        req1_last = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        req0_last = 1'b0;
        req1_last = 1'b0;

        // tie straight after reset: req0 first, req1 waits through IFG plus one IDLE cycle
        req1_valid = 1'b1;
        req1_data  = pat(1, 0);
        send_frame(0, 3, 1'b1, 3, 3, 1'b0);
        send_frame(1, 2, 1'b1, 2, 2, 1'b0);

        for (int v = 0; v < 8; v++)
            send_frame(vecs[v].req, vecs[v].n, vecs[v].use_last, vecs[v].avail,
                       vecs[v].exp_acc, vecs[v].exp_abort);

        // req0 served alone, so the next tie must go to req1
        send_frame(0, 1, 1'b1, 1, 1, 1'b0);
        req0_valid = 1'b1;
        req0_data  = pat(0, 0);
        send_frame(1, 2, 1'b1, 2, 2, 1'b0);
        send_frame(0, 2, 1'b1, 2, 2, 1'b0);

        // reset in the middle of DATA
        mon_en = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 8'h5A;
        req1_last  = 1'b0;
        repeat (12) @(posedge clock);
        @(negedge clock);
        check("pre_reset_in_frame", {14'd0, busy, gmii_tx_en}, 16'h0003);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", pack_act(), 16'h0000);
        @(posedge clock);
        #1;
        check("reset_held", pack_act(), 16'h0000);
        @(negedge clock);
        reset_n = 1'b1;
        req1_valid = 1'b0;
        @(posedge clock);
        #1;
        check("after_release", pack_act(), 16'h0000);
        exp_q.delete();
        mon_en = 1'b1;
        send_frame(1, 4, 1'b1, 4, 4, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
